// File: rtl/safe_lock_ctrl_if.sv
// Keypad/button command inputs and registered status outputs of the safe lock controller.
interface safe_lock_ctrl_if #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);

    logic          key_valid;
    logic [3:0]    key_code;
    logic          login_btn;
    logic          logout_btn;
    logic          chpw_btn;
    logic          cnf_btn;
    logic          bksp_btn;
    logic [DW-1:0] disp_digits;
    logic [CW-1:0] entry_cnt;
    logic [2:0]    state_o;
    logic          unlocked;
    logic          locked_out;
    logic [TW-1:0] tries_left;
    logic          err_pulse;
    logic          pw_changed;

    modport master (
        output key_valid, key_code, login_btn, logout_btn, chpw_btn, cnf_btn, bksp_btn,
        input  disp_digits, entry_cnt, state_o, unlocked, locked_out, tries_left,
               err_pulse, pw_changed
    );

    modport slave (
        input  key_valid, key_code, login_btn, logout_btn, chpw_btn, cnf_btn, bksp_btn,
        output disp_digits, entry_cnt, state_o, unlocked, locked_out, tries_left,
               err_pulse, pw_changed
    );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Keypad safe lock: passcode entry, confirm, passcode change and timed lockout after
// repeated failed confirms. All outputs are registered.
module safe_lock_ctrl #(
    parameter int unsigned             DIGITS      = 4,
    parameter int unsigned             MAX_TRIES   = 3,
    parameter int unsigned             LOCK_CYCLES = 1000,
    parameter logic [4*DIGITS-1:0]     DEFAULT_PW  = 16'h2301
) (
    input  logic              clk,
    input  logic              rst,
    safe_lock_ctrl_if.slave   bus
);
    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);
    localparam int unsigned MW = $clog2(LOCK_CYCLES + 1);

    localparam logic [DW-1:0] BLANK     = {DIGITS{4'hF}};
    localparam logic [DW-1:0] TOP_BLANK = DW'(4'hF) << (DW - 4);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ENTER   = 3'd1;
    localparam logic [2:0] OPEN    = 3'd2;
    localparam logic [2:0] NEWPW   = 3'd3;
    localparam logic [2:0] LOCKOUT = 3'd4;

    logic [2:0]    state_q,    state_d;
    logic [DW-1:0] pw_q,       pw_d;
    logic [DW-1:0] ent_q,      ent_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [TW-1:0] tries_q,    tries_d;
    logic [MW-1:0] timer_q,    timer_d;
    logic          err_q,      err_d;
    logic          chg_q,      chg_d;
    logic          unlocked_q, unlocked_d;
    logic          locked_q,   locked_d;

    logic full;
    logic match;
    logic clear;
    logic do_edit;

    assign full  = (cnt_q == CW'(DIGITS));
    assign match = (ent_q == pw_q);

    // Next-state, event pulses and entry-buffer editing
    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        ent_d      = ent_q;
        cnt_d      = cnt_q;
        tries_d    = tries_q;
        timer_d    = timer_q;
        err_d      = 1'b0;
        chg_d      = 1'b0;
        clear      = 1'b0;
        do_edit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.login_btn) begin
                    state_d = ENTER;
                    clear   = 1'b1;
                end
            end
            ENTER: begin
                if (bus.logout_btn) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else if (bus.cnf_btn) begin
                    if (!full) begin
                        err_d = 1'b1;
                    end else if (match) begin
                        state_d = OPEN;
                        tries_d = TW'(MAX_TRIES);
                        clear   = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        tries_d = tries_q - TW'(1);
                        // Buffer is kept on entry to lockout; it is blanked on the way back to IDLE
                        if (tries_q > TW'(1)) begin
                            state_d = IDLE;
                            clear   = 1'b1;
                        end else begin
                            state_d = LOCKOUT;
                            timer_d = MW'(LOCK_CYCLES);
                        end
                    end
                end else begin
                    do_edit = 1'b1;
                end
            end
            OPEN: begin
                if (bus.logout_btn) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else if (bus.chpw_btn) begin
                    state_d = NEWPW;
                    clear   = 1'b1;
                end
            end
            NEWPW: begin
                if (bus.logout_btn) begin
                    state_d = OPEN;
                    clear   = 1'b1;
                end else if (bus.cnf_btn) begin
                    if (full) begin
                        pw_d    = ent_q;
                        chg_d   = 1'b1;
                        state_d = OPEN;
                        clear   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    do_edit = 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer_q <= MW'(1)) begin
                    state_d = IDLE;
                    tries_d = TW'(MAX_TRIES);
                    timer_d = '0;
                    clear   = 1'b1;
                end else begin
                    timer_d = timer_q - MW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                clear   = 1'b1;
            end
        endcase

        // Backspace outranks a digit key arriving in the same cycle
        if (clear) begin
            ent_d = BLANK;
            cnt_d = '0;
        end else if (do_edit) begin
            if (bus.bksp_btn) begin
                if (cnt_q != '0) begin
                    ent_d = (ent_q >> 4) | TOP_BLANK;
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (bus.key_valid && (bus.key_code <= 4'd9) && !full) begin
                ent_d = (ent_q << 4) | DW'(bus.key_code);
                cnt_d = cnt_q + CW'(1);
            end
        end

        unlocked_d = (state_d == OPEN) || (state_d == NEWPW);
        locked_d   = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pw_q       <= DEFAULT_PW;
            ent_q      <= BLANK;
            cnt_q      <= '0;
            tries_q    <= TW'(MAX_TRIES);
            timer_q    <= '0;
            err_q      <= 1'b0;
            chg_q      <= 1'b0;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            ent_q      <= ent_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            chg_q      <= chg_d;
            unlocked_q <= unlocked_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.disp_digits = ent_q;
    assign bus.entry_cnt   = cnt_q;
    assign bus.state_o     = state_q;
    assign bus.unlocked    = unlocked_q;
    assign bus.locked_out  = locked_q;
    assign bus.tries_left  = tries_q;
    assign bus.err_pulse   = err_q;
    assign bus.pw_changed  = chg_q;
endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed and randomized bench for safe_lock_ctrl against a digit-queue reference model.
module tb_safe_lock_ctrl;
    localparam int unsigned DIGITS      = 4;
    localparam int unsigned MAX_TRIES   = 3;
    localparam int unsigned LOCK_CYCLES = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    safe_lock_ctrl_if #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES)) bus ();

    safe_lock_ctrl #(
        .DIGITS     (DIGITS),
        .MAX_TRIES  (MAX_TRIES),
        .LOCK_CYCLES(LOCK_CYCLES),
        .DEFAULT_PW (16'h2301)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 enter, 2 open, 3 newpw, 4 lockout
    int m_state;
    int m_q[$];
    int m_pw[DIGITS];
    int m_tries;
    int m_lock;
    bit m_err;
    bit m_chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] exp_disp();
        logic [4*DIGITS-1:0] d;
        int n;
        int v;
        d = '1;
        n = m_q.size();
        for (int i = 0; i < n; i++) begin
            v = m_q[n-1-i];
            d[4*i +: 4] = 4'(v);
        end
        return d;
    endfunction

    function automatic bit q_matches();
        if (m_q.size() != DIGITS) return 1'b0;
        for (int i = 0; i < int'(DIGITS); i++)
            if (m_q[i] != m_pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        m_pw    = '{2, 3, 0, 1};
        m_tries = MAX_TRIES;
        m_lock  = 0;
        m_err   = 0;
        m_chg   = 0;
    endtask

    task automatic model_edit(input bit bk, input bit kv, input int kc);
        if (bk) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (kv && kc <= 9 && m_q.size() < DIGITS) begin
            m_q.push_back(kc);
        end
    endtask

    task automatic model_step(input bit li, lo, ch, cf, bk, kv, input int kc);
        m_err = 0;
        m_chg = 0;
        case (m_state)
            0: if (li) begin m_state = 1; m_q.delete(); end
            1: begin
                if (lo) begin
                    m_state = 0; m_q.delete();
                end else if (cf) begin
                    if (m_q.size() < DIGITS) m_err = 1;
                    else if (q_matches()) begin
                        m_state = 2; m_tries = MAX_TRIES; m_q.delete();
                    end else begin
                        m_err = 1;
                        m_tries--;
                        if (m_tries > 0) begin m_state = 0; m_q.delete(); end
                        else begin m_state = 4; m_lock = LOCK_CYCLES; end
                    end
                end else model_edit(bk, kv, kc);
            end
            2: begin
                if (lo) begin m_state = 0; m_q.delete(); end
                else if (ch) begin m_state = 3; m_q.delete(); end
            end
            3: begin
                if (lo) begin
                    m_state = 2; m_q.delete();
                end else if (cf) begin
                    if (m_q.size() == DIGITS) begin
                        for (int i = 0; i < int'(DIGITS); i++) m_pw[i] = m_q[i];
                        m_chg = 1; m_state = 2; m_q.delete();
                    end else m_err = 1;
                end else model_edit(bk, kv, kc);
            end
            default: begin
                m_lock--;
                if (m_lock == 0) begin m_state = 0; m_tries = MAX_TRIES; m_q.delete(); end
            end
        endcase
    endtask

    task automatic check_all();
        check("state",      32'(bus.state_o),     32'(m_state));
        check("disp",       32'(bus.disp_digits), 32'(exp_disp()));
        check("entry_cnt",  32'(bus.entry_cnt),   32'(m_q.size()));
        check("tries",      32'(bus.tries_left),  32'(m_tries));
        check("unlocked",   32'(bus.unlocked),    32'(m_state == 2 || m_state == 3));
        check("locked_out", 32'(bus.locked_out),  32'(m_state == 4));
        check("err_pulse",  32'(bus.err_pulse),   32'(m_err));
        check("pw_changed", 32'(bus.pw_changed),  32'(m_chg));
    endtask

    // One clock: drive for one cycle, sample 1 time unit after the edge, advance model
    task automatic cyc(input bit r, li, lo, ch, cf, bk, kv, input int kc);
        rst            = r;
        bus.login_btn  = li;
        bus.logout_btn = lo;
        bus.chpw_btn   = ch;
        bus.cnf_btn    = cf;
        bus.bksp_btn   = bk;
        bus.key_valid  = kv;
        bus.key_code   = 4'(kc);
        @(posedge clk);
        #1;
        rst = 0; bus.login_btn = 0; bus.logout_btn = 0; bus.chpw_btn = 0;
        bus.cnf_btn = 0; bus.bksp_btn = 0; bus.key_valid = 0; bus.key_code = 4'd0;
        if (r) model_reset();
        else   model_step(li, lo, ch, cf, bk, kv, kc);
        check_all();
    endtask

    task automatic do_reset(); cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic idle1();    cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic login();    cyc(0, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic logout();   cyc(0, 0, 1, 0, 0, 0, 0, 0); endtask
    task automatic chpw();     cyc(0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic cnf();      cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic bksp();     cyc(0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic key(input int d); cyc(0, 0, 0, 0, 0, 0, 1, d); endtask

    task automatic enter4(input int a, b, c, d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic rand_cyc(input bit allow_rst);
        cyc(allow_rst && ($urandom_range(0, 499) == 0),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 0,
            int'($urandom_range(0, 15)));
    endtask

    int n;

    initial begin
        model_reset();
        do_reset();
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_disp",  32'(bus.disp_digits), 32'hFFFF);
        check("rst_tries", 32'(bus.tries_left), 32'd3);

        // Default passcode opens
        login(); enter4(2, 3, 0, 1); cnf();
        check("open_state", 32'(bus.state_o), 32'd2);
        check("open_unlocked", 32'(bus.unlocked), 32'd1);
        check("open_tries", 32'(bus.tries_left), 32'd3);
        logout();

        // Backspace, invalid key, full-buffer ignore
        login(); key(5); key(6); bksp(); bksp(); bksp(); key(12); key(7);
        check("bksp_disp", 32'(bus.disp_digits), 32'hFFF7);
        check("bksp_cnt", 32'(bus.entry_cnt), 32'd1);
        key(1); key(2); key(3); key(8);
        check("full_disp", 32'(bus.disp_digits), 32'h7123);
        check("full_cnt", 32'(bus.entry_cnt), 32'd4);

        // Short confirm, then logout+cnf together
        bksp(); cnf();
        check("short_err", 32'(bus.err_pulse), 32'd1);
        check("short_tries", 32'(bus.tries_left), 32'd3);
        cyc(0, 0, 1, 0, 1, 0, 0, 0);
        check("abort_state", 32'(bus.state_o), 32'd0);
        check("abort_tries", 32'(bus.tries_left), 32'd3);

        // Three wrong codes then lockout dwell with random inputs
        for (int t = 0; t < 3; t++) begin
            login(); enter4(9, 9, 9, 9); cnf();
            check("wrong_err", 32'(bus.err_pulse), 32'd1);
            if (t < 2) check("wrong_tries", 32'(bus.tries_left), 32'(2 - t));
        end
        check("lock_flag", 32'(bus.locked_out), 32'd1);
        n = 1;
        while (bus.locked_out && n < 3000) begin
            rand_cyc(0);
            if (bus.locked_out) n++;
        end
        check("lock_dwell", 32'(n), 32'(LOCK_CYCLES));
        check("lock_exit_state", 32'(bus.state_o), 32'd0);
        check("lock_exit_tries", 32'(bus.tries_left), 32'd3);

        // Passcode change; new code works, old fails
        login(); enter4(2, 3, 0, 1); cnf(); chpw();
        check("newpw_state", 32'(bus.state_o), 32'd3);
        enter4(4, 4, 4, 4); cnf();
        check("chg_pulse", 32'(bus.pw_changed), 32'd1);
        check("chg_state", 32'(bus.state_o), 32'd2);
        logout(); login(); enter4(4, 4, 4, 4); cnf();
        check("new_open", 32'(bus.state_o), 32'd2);
        logout(); login(); enter4(2, 3, 0, 1); cnf();
        check("old_fail_err", 32'(bus.err_pulse), 32'd1);
        check("old_fail_tries", 32'(bus.tries_left), 32'd2);

        // NEWPW short confirm and logout-to-OPEN
        login(); enter4(4, 4, 4, 4); cnf(); chpw(); key(1); cnf();
        check("newpw_short_err", 32'(bus.err_pulse), 32'd1);
        check("newpw_short_state", 32'(bus.state_o), 32'd3);
        logout();
        check("newpw_abort_state", 32'(bus.state_o), 32'd2);
        logout();

        // Reset during lockout restores default passcode
        for (int t = 0; t < 3; t++) begin
            login(); enter4(2, 3, 0, 1); cnf();
        end
        check("lock2_flag", 32'(bus.locked_out), 32'd1);
        repeat (5) idle1();
        do_reset();
        check("rst_lock_state", 32'(bus.state_o), 32'd0);
        check("rst_lock_tries", 32'(bus.tries_left), 32'd3);
        login(); enter4(2, 3, 0, 1); cnf();
        check("rst_default_open", 32'(bus.state_o), 32'd2);
        logout();

        // Random traffic with occasional correct logins
        repeat (4000) begin
            if (m_state == 0 && $urandom_range(0, 9) == 0) begin
                login();
                for (int i = 0; i < int'(DIGITS); i++) key(m_pw[i]);
                cnf();
            end else begin
                rand_cyc(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/safe_lock_ctrl.md
SAFE_LOCK_CTRL -- requirements
Module: safe_lock_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning passcode length in decimal digits (legal range 1..8).
REQ-002 SHALL have parameter MAX_TRIES, default 3, meaning failed confirms allowed before lockout (at least 1).
REQ-003 SHALL have parameter LOCK_CYCLES, default 1000, meaning lockout duration in clk cycles (at least 1).
REQ-004 SHALL have parameter DEFAULT_PW, width 4*DIGITS, default 16'h2301, meaning reset passcode as BCD nibbles; nibble 0 is the last digit entered.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is posedge clk.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port key_valid, input, 1 bit: one-cycle pulse meaning key_code is valid.
REQ-008 SHALL have port key_code, input, 4 bits: digit value 0..9.
REQ-009 SHALL have ports login_btn, logout_btn, chpw_btn, cnf_btn and bksp_btn, each input, 1 bit: one-cycle command pulses, debounced upstream.
REQ-010 SHALL have port disp_digits, output, 4*DIGITS bits: entry buffer for the display; 4'hF means blank.
REQ-011 SHALL have port entry_cnt, output, $clog2(DIGITS+1) bits: digits currently entered.
REQ-012 SHALL have port state_o, output, 3 bits: IDLE=0, ENTER=1, OPEN=2, NEWPW=3, LOCKOUT=4.
REQ-013 SHALL have ports unlocked and locked_out, outputs, 1 bit each: high in OPEN/NEWPW and in LOCKOUT respectively.
REQ-014 SHALL have port tries_left, output, $clog2(MAX_TRIES+1) bits: remaining failed attempts.
REQ-015 SHALL have ports err_pulse and pw_changed, outputs, 1 bit each: one-cycle event pulses.

Function
REQ-016 SHALL register all outputs; a state change is visible one cycle after the triggering pulse.
REQ-017 Entry (ENTER or NEWPW) SHALL accept key_valid with key_code<=9 and entry_cnt<DIGITS: buffer shifts left one nibble, the new digit goes into nibble 0, and entry_cnt increments.
REQ-018 Entry SHALL ignore key_code>9 and SHALL ignore keys when entry_cnt==DIGITS (buffer full, no error).
REQ-019 bksp_btn with entry_cnt>0 SHALL shift the buffer right one nibble, fill the top nibble with 4'hF, and decrement entry_cnt; with entry_cnt==0 it SHALL be ignored.
REQ-020 Same-cycle priority SHALL be: logout_btn, then cnf_btn, then bksp_btn, then key_valid; lower-priority events are dropped.
REQ-021 IDLE: login_btn SHALL move to ENTER; all other inputs are ignored.
REQ-022 ENTER, cnf_btn with entry_cnt<DIGITS: SHALL assert err_pulse, stay in ENTER, and leave tries_left unchanged.
REQ-023 ENTER, cnf_btn with a full buffer that matches the passcode: SHALL go to OPEN and reload tries_left=MAX_TRIES.
REQ-024 ENTER, cnf_btn with a full buffer that mismatches: SHALL assert err_pulse and decrement tries_left; go to IDLE if the result is >0, else go to LOCKOUT with the timer set to LOCK_CYCLES.
REQ-025 ENTER, logout_btn: SHALL abort to IDLE with no try consumed.
REQ-026 OPEN: logout_btn SHALL go to IDLE; chpw_btn SHALL go to NEWPW.
REQ-027 NEWPW, cnf_btn with a full buffer: SHALL write the buffer to the passcode register, pulse pw_changed, and go to OPEN.
REQ-028 NEWPW, cnf_btn when not full: SHALL pulse err_pulse only.
REQ-029 NEWPW, logout_btn: SHALL return to OPEN with the passcode unchanged.
REQ-030 LOCKOUT: SHALL ignore all inputs and decrement the timer each cycle; on the cycle the timer equals 1 it SHALL go to IDLE and reload tries_left=MAX_TRIES, so dwell is exactly LOCK_CYCLES cycles.
REQ-031 Every transition into ENTER, NEWPW, IDLE or OPEN SHALL clear the buffer to all 4'hF and set entry_cnt=0.
REQ-032 Passcode compare SHALL be full-width equality over 4*DIGITS bits.

Reset
REQ-033 On rst: state IDLE, passcode=DEFAULT_PW, buffer all 4'hF, entry_cnt=0, tries_left=MAX_TRIES, timer=0, and all 1-bit outputs low.
REQ-034 rst SHALL override every input in the same cycle, including mid-entry and mid-lockout, and SHALL restore the passcode to DEFAULT_PW.

Verification (defaults)
REQ-035 login, keys 2,3,0,1, cnf -> state_o=2, unlocked=1, tries_left=3.
REQ-036 login, keys 9,9,9,9, cnf, repeated 3 times -> err_pulse each time; tries_left 2, 1, then locked_out=1 for exactly 1000 cycles, then IDLE with tries_left=3.
REQ-037 login, keys 5,6, bksp, bksp, bksp, 7 -> disp_digits=16'hFFF7, entry_cnt=1; a fifth key after the buffer is full is ignored.
REQ-038 OPEN, chpw, keys 4,4,4,4, cnf -> pw_changed pulse; logout, login, 4,4,4,4, cnf -> OPEN; the old code 2301 fails.
REQ-039 cnf at entry_cnt=3 -> err_pulse, tries_left unchanged; logout and cnf in the same cycle -> IDLE, no try consumed.
REQ-040 rst asserted in LOCKOUT after a passcode change -> IDLE, tries_left=3, and 2301 opens.
